// File: rtl/axil_reg_slave_if.sv
// rtl/axil_reg_slave_if.sv - AXI4-Lite bus bundle between the interconnect master and the register slave
interface axil_reg_slave_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axil_reg_slave.sv
// rtl/axil_reg_slave.sv - AXI4-Lite register bank slave; optional per-register write pulse under AXIL_REG_WR_PULSE_EN
module axil_reg_slave #(
    parameter int          ADDR_W    = 32,
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter logic [31:0] ID_VALUE  = 32'hA11E_0001
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    axil_reg_slave_if.slave        bus,
`ifdef AXIL_REG_WR_PULSE_EN
    output logic [NUM_REGS-1:0]    o_wr_pulse,
`endif
    output logic [NUM_REGS*32-1:0] o_regs
);
    localparam int                IDX_W  = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] WIN    = ADDR_W'(NUM_REGS * 4);
    localparam logic [1:0]        OKAY   = 2'b00;
    localparam logic [1:0]        SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
        return (a >= BASE_A) && ((a - BASE_A) < WIN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_A) >> 2);
    endfunction

    logic [31:0]       regs_q [NUM_REGS];

    w_state_t          w_state, w_state_n;
    logic              aw_full, aw_full_n, w_full, w_full_n;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic              awready_q, awready_n, wready_q, wready_n;
    logic              bvalid_q, bvalid_n;
    logic [1:0]        bresp_q, bresp_n;
    logic              wr_commit, wr_ok;
    logic [IDX_W-1:0]  wr_idx;

    r_state_t          r_state, r_state_n;
    logic              arready_q, arready_n, rvalid_q, rvalid_n;
    logic [31:0]       rdata_q, rdata_n;
    logic [1:0]        rresp_q, rresp_n;
    logic              rd_hit;
    logic [IDX_W-1:0]  rd_idx;

    assign wr_idx    = addr_idx(aw_addr_q);
    assign wr_ok     = addr_hit(aw_addr_q) && (wr_idx != '0);
    assign wr_commit = (w_state == W_IDLE) && aw_full && w_full;
    assign rd_hit    = addr_hit(bus.s_araddr);
    assign rd_idx    = addr_idx(bus.s_araddr);

    // Write FSM next state: fill the AW/W buffers independently, commit once both are full
    always_comb begin
        w_state_n = w_state;
        aw_full_n = aw_full;
        w_full_n  = w_full;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        case (w_state)
            W_IDLE: begin
                if (aw_full && w_full) begin
                    w_state_n = W_RESP;
                    bvalid_n  = 1'b1;
                    bresp_n   = wr_ok ? OKAY : SLVERR;
                end else begin
                    if (awready_q && bus.s_awvalid) aw_full_n = 1'b1;
                    if (wready_q && bus.s_wvalid)   w_full_n  = 1'b1;
                end
            end
            W_RESP: begin
                if (bus.s_bready) begin
                    w_state_n = W_IDLE;
                    bvalid_n  = 1'b0;
                    aw_full_n = 1'b0;
                    w_full_n  = 1'b0;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
        awready_n = (w_state_n == W_IDLE) && !aw_full_n;
        wready_n  = (w_state_n == W_IDLE) && !w_full_n;
    end

    // Write FSM state, holding buffers and registered AW/W/B handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_state   <= W_IDLE;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            w_state   <= w_state_n;
            aw_full   <= aw_full_n;
            w_full    <= w_full_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
            if (awready_q && bus.s_awvalid) aw_addr_q <= bus.s_awaddr;
            if (wready_q && bus.s_wvalid) begin
                w_data_q <= bus.s_wdata;
                w_strb_q <= bus.s_wstrb;
            end
        end
    end

    // Register bank: register 0 is pinned to the ID constant, others take strobed bytes on commit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= (k == 0) ? ID_VALUE : 32'h0;
        end else begin
            regs_q[0] <= ID_VALUE;
            if (wr_commit && wr_ok) begin
                for (int k = 1; k < NUM_REGS; k++) begin
                    if (wr_idx == IDX_W'(k)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (w_strb_q[b]) regs_q[k][8*b +: 8] <= w_data_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

`ifdef AXIL_REG_WR_PULSE_EN
    // One-cycle strobe per successful write, aligned with the o_regs update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wr_pulse <= '0;
        end else begin
            o_wr_pulse <= '0;
            if (wr_commit && wr_ok) o_wr_pulse[wr_idx] <= 1'b1;
        end
    end
`endif

    // Read FSM next state: capture data on the AR handshake, hold it until rready
    always_comb begin
        r_state_n = r_state;
        rvalid_n  = rvalid_q;
        rdata_n   = rdata_q;
        rresp_n   = rresp_q;
        case (r_state)
            R_IDLE: begin
                if (arready_q && bus.s_arvalid) begin
                    r_state_n = R_DATA;
                    rvalid_n  = 1'b1;
                    rdata_n   = rd_hit ? regs_q[rd_idx] : 32'h0;
                    rresp_n   = rd_hit ? OKAY : SLVERR;
                end
            end
            R_DATA: begin
                if (bus.s_rready) begin
                    r_state_n = R_IDLE;
                    rvalid_n  = 1'b0;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
        arready_n = (r_state_n == R_IDLE);
    end

    // Read FSM state and registered AR/R outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            r_state   <= r_state_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rdata_q   <= rdata_n;
            rresp_q   <= rresp_n;
        end
    end

    assign bus.s_awready = awready_q;
    assign bus.s_wready  = wready_q;
    assign bus.s_bvalid  = bvalid_q;
    assign bus.s_bresp   = bresp_q;
    assign bus.s_arready = arready_q;
    assign bus.s_rvalid  = rvalid_q;
    assign bus.s_rdata   = rdata_q;
    assign bus.s_rresp   = rresp_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign o_regs[32*g +: 32] = regs_q[g];
    end
endmodule
